// File: rtl/zbus_arbiter_if.sv
// rtl/zbus_arbiter_if.sv - grouped requester-side and output-side zbus signals for the arbiter
interface zbus_arbiter_if #(
    parameter int BW = 8,
    parameter int PN = 4,
    parameter int SW = (PN > 1) ? $clog2(PN) : 1
);
    logic [PN-1:0]    zi_vld;
    logic [PN*BW-1:0] zi_bus;
    logic [PN-1:0]    zi_lst;
    logic [PN-1:0]    zi_ack;
    logic             zo_vld;
    logic [BW-1:0]    zo_bus;
    logic             zo_lst;
    logic [SW-1:0]    zo_sel;
    logic             zo_ack;
    logic             zo_bsy;

    // arbiter side
    modport slave (
        input  zi_vld, zi_bus, zi_lst, zo_ack,
        output zi_ack, zo_vld, zo_bus, zo_lst, zo_sel, zo_bsy
    );

    // requesters plus downstream sink
    modport master (
        output zi_vld, zi_bus, zi_lst, zo_ack,
        input  zi_ack, zo_vld, zo_bus, zo_lst, zo_sel, zo_bsy
    );
endinterface

// File: rtl/zbus_arbiter.sv
// rtl/zbus_arbiter.sv - round-robin packet-locking zbus arbiter with registered output stage
module zbus_arbiter #(
    parameter int BW = 8,
    parameter int PN = 4,
    parameter int SW = (PN > 1) ? $clog2(PN) : 1
) (
    input  logic          zbus_clk,
    input  logic          zbus_rst,
    zbus_arbiter_if.slave zb
);
    localparam logic [SW:0]   PN_W = (SW+1)'(PN);
    localparam logic [SW-1:0] LAST = SW'(PN - 1);

    typedef enum logic {S_IDLE, S_LOCK} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] rpt_q, rpt_d;
    logic [SW-1:0] own_q, own_d;
    logic          zo_vld_q, zo_vld_d;
    logic [BW-1:0] zo_bus_q, zo_bus_d;
    logic          zo_lst_q, zo_lst_d;
    logic [SW-1:0] zo_sel_q, zo_sel_d;

    logic          ld_ok;
    logic          scan_hit;
    logic [SW-1:0] scan_sel;
    logic [SW:0]   sum;
    logic [SW-1:0] sel;
    logic          req;
    logic          xfer;
    logic [PN-1:0] ack;
    logic [BW-1:0] beat_bus;
    logic          beat_lst;
    logic [SW-1:0] sel_inc;

    // Pick the granted requester: rotating priority scan when idle, the owner when locked.
    // The scan wraps modulo PN so non-power-of-two port counts never see phantom indices.
    always_comb begin
        ld_ok    = ~zo_vld_q | zb.zo_ack;
        scan_hit = 1'b0;
        scan_sel = '0;
        sum      = '0;
        for (int k = 0; k < PN; k++) begin
            sum = {1'b0, rpt_q} + (SW+1)'(k);
            if (sum >= PN_W) begin
                sum = sum - PN_W;
            end
            if (!scan_hit && zb.zi_vld[sum[SW-1:0]]) begin
                scan_hit = 1'b1;
                scan_sel = sum[SW-1:0];
            end
        end
        if (state_q == S_LOCK) begin
            sel = own_q;
            req = zb.zi_vld[own_q];
        end else begin
            sel = scan_sel;
            req = scan_hit;
        end
        xfer = ~zbus_rst & req & ld_ok;
        ack  = '0;
        if (xfer) begin
            ack[sel] = 1'b1;
        end
        beat_bus = zb.zi_bus[int'(sel)*BW +: BW];
        beat_lst = zb.zi_lst[sel];
        sel_inc  = (sel == LAST) ? '0 : sel + 1'b1;
    end

    // Next state: a moving beat refills the output register and advances lock/pointer;
    // a drain with nothing new only clears valid so the data fields keep their last value.
    always_comb begin
        state_d  = state_q;
        rpt_d    = rpt_q;
        own_d    = own_q;
        zo_vld_d = zo_vld_q;
        zo_bus_d = zo_bus_q;
        zo_lst_d = zo_lst_q;
        zo_sel_d = zo_sel_q;
        if (xfer) begin
            zo_vld_d = 1'b1;
            zo_bus_d = beat_bus;
            zo_lst_d = beat_lst;
            zo_sel_d = sel;
            if (beat_lst) begin
                state_d = S_IDLE;
                rpt_d   = sel_inc;
            end else begin
                state_d = S_LOCK;
                own_d   = sel;
            end
        end else if (zb.zo_ack) begin
            zo_vld_d = 1'b0;
        end
    end

    // State, pointer and output register; reset drops any held beat and releases the lock.
    always_ff @(posedge zbus_clk) begin
        if (zbus_rst) begin
            state_q  <= S_IDLE;
            rpt_q    <= '0;
            own_q    <= '0;
            zo_vld_q <= 1'b0;
            zo_bus_q <= '0;
            zo_lst_q <= 1'b0;
            zo_sel_q <= '0;
        end else begin
            state_q  <= state_d;
            rpt_q    <= rpt_d;
            own_q    <= own_d;
            zo_vld_q <= zo_vld_d;
            zo_bus_q <= zo_bus_d;
            zo_lst_q <= zo_lst_d;
            zo_sel_q <= zo_sel_d;
        end
    end

    assign zb.zi_ack = ack;
    assign zb.zo_vld = zo_vld_q;
    assign zb.zo_bus = zo_bus_q;
    assign zb.zo_lst = zo_lst_q;
    assign zb.zo_sel = zo_sel_q;
    assign zb.zo_bsy = (state_q == S_LOCK);
endmodule
